costas_nco: RTL and testbench

//   Numerically controlled oscillator that closes the Costas carrier loop: it consumes the loop filter's

---
 rtl/costas_nco.sv | 184 ++++++++++++++++++
 tb/tb_costas_nco.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/costas_nco.sv
`default_nettype none
// ============================================================================
// Module   : costas_nco
// Function : Costas-loop NCO. A phase accumulator is steered by a clamped
//            frequency correction and drives a quarter-wave sine LUT through a
//            3-stage pipeline that produces quadrature cos/sin samples.
// Option   : define COSTAS_NCO_DITHER_EN to add LFSR phase dither ahead of
//            the LUT lookup.
// Revision : 1.0  initial release
// ============================================================================
module costas_nco #(
  parameter int unsigned        WIDTH       = 32,
  parameter int unsigned        PHASE_W     = 32,
  parameter int unsigned        LUT_AW      = 8,
  parameter int unsigned        OUT_W       = 16,
  parameter logic [PHASE_W-1:0] CENTER_FREQ = 32'h4000_0000,
  parameter int unsigned        CORR_SHIFT  = 0,
  parameter logic [PHASE_W-1:0] MAX_CORR    = 32'h0100_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   freq_err_in,
  input  logic               freq_valid,
  input  logic               enable,
  output logic [PHASE_W-1:0] phase_out,
  output logic [OUT_W-1:0]   cos_out,
  output logic [OUT_W-1:0]   sin_out,
  output logic               out_valid
);

  localparam int unsigned CW      = ((WIDTH > PHASE_W) ? WIDTH : PHASE_W) + 1;
  localparam int unsigned QW      = LUT_AW + 2;
  localparam int unsigned LUT_N   = 1 << LUT_AW;
  localparam int unsigned TRUNC_W = PHASE_W - QW;
  localparam logic [QW-1:0] QUARTER_IDX = {2'b01, {LUT_AW{1'b0}}};

  // Quarter-wave table sampled at bin centres, so no entry is zero and the
  // largest stays one LSB under full scale, keeping negation symmetric.
  function automatic logic [OUT_W-1:0] lut_entry(input int unsigned idx);
    real amp;
    real ang;
    amp = real'((1 << (OUT_W - 1)) - 2);
    ang = (3.14159265358979323846 / 2.0) * (real'(idx) + 0.5) / real'(LUT_N);
    return OUT_W'($rtoi(amp * $sin(ang) + 0.5));
  endfunction

  logic [OUT_W-1:0] w_lut [LUT_N];

  generate
    for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
      localparam logic [OUT_W-1:0] LUT_VAL = lut_entry(gi);
      assign w_lut[gi] = LUT_VAL;
    end
  endgenerate

  logic signed [WIDTH-1:0] w_err_shift;
  logic signed [CW-1:0]    w_err_ext;
  logic signed [CW-1:0]    w_max;
  logic signed [CW-1:0]    w_min;
  logic signed [CW-1:0]    w_clamp;
  logic [CW-PHASE_W-1:0]   w_unused_clamp_msbs;

  logic [PHASE_W-1:0] corr_q,  corr_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] w_lut_phase;
  logic [QW-1:0]      w_sin_idx;
  logic [QW-1:0]      w_cos_idx;

  assign w_err_shift = $signed(freq_err_in) >>> CORR_SHIFT;
  assign w_err_ext   = {{(CW - WIDTH){w_err_shift[WIDTH-1]}}, w_err_shift};
  assign w_max       = {{(CW - PHASE_W){1'b0}}, MAX_CORR};
  assign w_min       = -w_max;

  always_comb begin
    w_clamp = w_err_ext;
    if (w_err_ext > w_max) begin
      w_clamp = w_max;
    end else if (w_err_ext < w_min) begin
      w_clamp = w_min;
    end
  end

  assign w_unused_clamp_msbs = w_clamp[CW-1:PHASE_W];
  assign corr_d  = w_clamp[PHASE_W-1:0];
  assign phase_d = phase_q + CENTER_FREQ + corr_q;

`ifdef COSTAS_NCO_DITHER_EN
  logic [15:0]        lfsr_q;
  logic [PHASE_W-1:0] w_dither;
  logic [TRUNC_W-1:0] w_unused_lut_low;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= 16'hACE1;
    end else if (enable) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  generate
    if (TRUNC_W >= 16) begin : g_dith_wide
      assign w_dither = {{(PHASE_W - 16){1'b0}}, lfsr_q};
    end else begin : g_dith_narrow
      assign w_dither = {{QW{1'b0}}, lfsr_q[TRUNC_W-1:0]};
    end
  endgenerate

  assign w_lut_phase      = phase_q + w_dither;
  assign w_unused_lut_low = w_lut_phase[TRUNC_W-1:0];
`else
  assign w_lut_phase = phase_q;
`endif

  // Cosine is the sine a quarter turn ahead; only the quadrant bits move.
  assign w_sin_idx = w_lut_phase[PHASE_W-1 -: QW];
  assign w_cos_idx = w_sin_idx + QUARTER_IDX;

  logic               s1_v_q;
  logic [PHASE_W-1:0] s1_phase_q;
  logic [QW-1:0]      s1_sin_idx_q;
  logic [QW-1:0]      s1_cos_idx_q;
  logic               s2_v_q;
  logic [PHASE_W-1:0] s2_phase_q;
  logic [OUT_W-1:0]   s2_sin_mag_q;
  logic [OUT_W-1:0]   s2_cos_mag_q;
  logic               s2_sin_neg_q;
  logic               s2_cos_neg_q;
  logic [LUT_AW-1:0]  w_sin_addr;
  logic [LUT_AW-1:0]  w_cos_addr;

  assign w_sin_addr = s1_sin_idx_q[LUT_AW-1:0] ^ {LUT_AW{s1_sin_idx_q[LUT_AW]}};
  assign w_cos_addr = s1_cos_idx_q[LUT_AW-1:0] ^ {LUT_AW{s1_cos_idx_q[LUT_AW]}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      corr_q       <= '0;
      phase_q      <= '0;
      s1_v_q       <= 1'b0;
      s1_phase_q   <= '0;
      s1_sin_idx_q <= '0;
      s1_cos_idx_q <= '0;
      s2_v_q       <= 1'b0;
      s2_phase_q   <= '0;
      s2_sin_mag_q <= '0;
      s2_cos_mag_q <= '0;
      s2_sin_neg_q <= 1'b0;
      s2_cos_neg_q <= 1'b0;
      out_valid    <= 1'b0;
      phase_out    <= '0;
      sin_out      <= '0;
      cos_out      <= '0;
    end else begin
      if (freq_valid) begin
        corr_q <= corr_d;
      end
      if (enable) begin
        phase_q      <= phase_d;
        s1_phase_q   <= phase_q;
        s1_sin_idx_q <= w_sin_idx;
        s1_cos_idx_q <= w_cos_idx;
      end
      s1_v_q <= enable;

      if (s1_v_q) begin
        s2_phase_q   <= s1_phase_q;
        s2_sin_mag_q <= w_lut[w_sin_addr];
        s2_cos_mag_q <= w_lut[w_cos_addr];
        s2_sin_neg_q <= s1_sin_idx_q[QW-1];
        s2_cos_neg_q <= s1_cos_idx_q[QW-1];
      end
      s2_v_q <= s1_v_q;

      // Outputs only update on a valid sample and hold otherwise.
      if (s2_v_q) begin
        phase_out <= s2_phase_q;
        sin_out   <= s2_sin_neg_q ? -s2_sin_mag_q : s2_sin_mag_q;
        cos_out   <= s2_cos_neg_q ? -s2_cos_mag_q : s2_cos_mag_q;
      end
      out_valid <= s2_v_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_costas_nco.sv
`default_nettype none
// ============================================================================
// Module   : tb_costas_nco
// Function : Self-checking bench for costas_nco against a trigonometric
//            reference model, directed tables and randomized traffic.
// Revision : 1.0  initial release
// ============================================================================
module tb_costas_nco;

  localparam real PI  = 3.14159265358979323846;
  localparam real AMP = 32766.0;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] freq_err_in;
  logic        freq_valid;
  logic        enable;
  logic [31:0] phase_out;
  logic [15:0] cos_out;
  logic [15:0] sin_out;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  costas_nco dut (
    .clk        (clk),
    .reset      (reset),
    .freq_err_in(freq_err_in),
    .freq_valid (freq_valid),
    .enable     (enable),
    .phase_out  (phase_out),
    .cos_out    (cos_out),
    .sin_out    (sin_out),
    .out_valid  (out_valid)
  );

  typedef struct {
    bit          v;
    logic [31:0] p;
  } samp_t;

  typedef struct {
    logic [31:0] err;
    logic [31:0] step;
  } corr_vec_t;

  typedef struct {
    logic [31:0] p;
    int          s;
    int          c;
  } fs4_vec_t;

  logic [31:0] m_phase;
  logic [31:0] m_corr;
  samp_t       m_pipe[$];
  bit          exp_v;
  bit          exp_any;
  logic [31:0] exp_p;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_near(input string name, input longint act, input longint exp);
    longint diff;
    longint tol;
`ifdef COSTAS_NCO_DITHER_EN
    tol = 201;
`else
    tol = 0;
`endif
    diff = (act > exp) ? act - exp : exp - act;
    checks++;
    if (diff > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Ideal sample of the bin containing phase p, scaled and rounded half away from zero.
  function automatic int ref_wave(input logic [31:0] p, input bit is_cos, input int bin_off);
    int  k;
    real ang;
    real x;
    k   = (int'(p >> 22) + bin_off) % 1024;
    ang = 2.0 * PI * (real'(k) + 0.5) / 1024.0;
    x   = AMP * (is_cos ? $cos(ang) : $sin(ang));
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  task automatic chk_wave(input string name, input logic signed [15:0] act,
                          input logic [31:0] p, input bit is_cos);
    int a0;
    bit ok;
    a0 = ref_wave(p, is_cos, 0);
    ok = (int'(act) == a0);
`ifdef COSTAS_NCO_DITHER_EN
    ok = ok || (int'(act) == ref_wave(p, is_cos, 1));
`endif
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (phase %h) at %0t", name, int'(act), a0, p, $time);
    end
  endtask

  function automatic logic [31:0] clampf(input logic [31:0] e);
    longint s;
    s = longint'($signed(e));
    if (s > 64'sh0100_0000)  s = 64'sh0100_0000;
    if (s < -64'sh0100_0000) s = -64'sh0100_0000;
    return s[31:0];
  endfunction

  task automatic model_clear();
    m_phase = '0;
    m_corr  = '0;
    m_pipe.delete();
    exp_v   = 1'b0;
    exp_any = 1'b0;
    exp_p   = '0;
  endtask

  // One clock: advance the model with the inputs presently driven, then check.
  task automatic tick();
    samp_t s;
    s.v = enable;
    s.p = m_phase;
    m_pipe.push_back(s);
    if (enable)     m_phase = m_phase + 32'h4000_0000 + m_corr;
    if (freq_valid) m_corr  = clampf(freq_err_in);
    if (m_pipe.size() == 3) begin
      s     = m_pipe.pop_front();
      exp_v = s.v;
      if (s.v) begin
        exp_p   = s.p;
        exp_any = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", longint'(out_valid), longint'(exp_v));
    chk("phase_out", longint'(phase_out), longint'(exp_p));
    if (exp_any) begin
      chk_wave("sin_out", sin_out, exp_p, 1'b0);
      chk_wave("cos_out", cos_out, exp_p, 1'b1);
    end else begin
      chk("sin_idle", longint'($signed(sin_out)), 0);
      chk("cos_idle", longint'($signed(cos_out)), 0);
    end
  endtask

  task automatic reset_midstream();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async_valid", longint'(out_valid), 0);
    chk("rst_async_phase", longint'(phase_out), 0);
    chk("rst_async_sin", longint'($signed(sin_out)), 0);
    chk("rst_async_cos", longint'($signed(cos_out)), 0);
    model_clear();
    @(posedge clk);
    #1;
    chk("rst_hold_valid", longint'(out_valid), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    corr_vec_t   cv[8];
    fs4_vec_t    fs4[4];
    bit          gap_pat[10];
    logic [31:0] p0;
    logic [31:0] d;

    cv[0] = '{err: 32'h0000_0000, step: 32'h4000_0000};
    cv[1] = '{err: 32'h0000_1000, step: 32'h4000_1000};
    cv[2] = '{err: 32'h7FFF_FFFF, step: 32'h4100_0000};
    cv[3] = '{err: 32'h8000_0000, step: 32'h3F00_0000};
    cv[4] = '{err: 32'h0100_0000, step: 32'h4100_0000};
    cv[5] = '{err: 32'hFEFF_FFFF, step: 32'h3F00_0000};
    cv[6] = '{err: 32'hFFFF_FFFF, step: 32'h3FFF_FFFF};
    cv[7] = '{err: 32'h00FF_FFFF, step: 32'h40FF_FFFF};

    fs4[0] = '{p: 32'h0000_0000, s: 101,    c: 32766};
    fs4[1] = '{p: 32'h4000_0000, s: 32766,  c: -101};
    fs4[2] = '{p: 32'h8000_0000, s: -101,   c: -32766};
    fs4[3] = '{p: 32'hC000_0000, s: -32766, c: 101};

    gap_pat = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 1};

    // Reset held low while enable is high: everything stays cleared.
    reset       = 1'b0;
    enable      = 1'b1;
    freq_valid  = 1'b0;
    freq_err_in = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", longint'(out_valid), 0);
    chk("reset_phase", longint'(phase_out), 0);
    chk("reset_sin", longint'($signed(sin_out)), 0);
    chk("reset_cos", longint'($signed(cos_out)), 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("first_valid_latency", longint'(out_valid), (i == 3) ? 1 : 0);
    end

    // Free-running at fs/4.
    for (int i = 0; i < 8; i++) begin
      chk("fs4_phase", longint'(phase_out), longint'(fs4[i % 4].p));
      chk_near("fs4_sin", longint'($signed(sin_out)), longint'(fs4[i % 4].s));
      chk_near("fs4_cos", longint'($signed(cos_out)), longint'(fs4[i % 4].c));
      tick();
    end

    // Correction table: pulse freq_valid, then measure the settled step.
    for (int i = 0; i < 8; i++) begin
      freq_valid  = 1'b1;
      freq_err_in = cv[i].err;
      tick();
      freq_valid  = 1'b0;
      freq_err_in = $urandom;
      repeat (6) tick();
      p0 = phase_out;
      tick();
      d = phase_out - p0;
      chk("corr_step", longint'(d), longint'(cv[i].step));
    end

    // Enable gaps reappear on out_valid two edges later with the phase held.
    for (int j = 0; j < 10; j++) begin
      enable = gap_pat[j];
      tick();
      if (j >= 2) chk("gap_valid", longint'(out_valid), longint'(gap_pat[j-2]));
    end
    enable = 1'b1;

    reset_midstream();
    repeat (5) tick();

    // Randomized traffic with one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      enable     = ($urandom_range(0, 3) != 0);
      freq_valid = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       freq_err_in = $urandom;
        1:       freq_err_in = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        2:       freq_err_in = $urandom_range(0, 32'h0200_0000) - 32'h0100_0000;
        default: freq_err_in = $urandom & 32'h0000_FFFF;
      endcase
      tick();
      if (i == 1500) reset_midstream();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
